// File: rtl/feature_map_streamer_if.sv
// feature_map_streamer_if: byte-stream valid/ready handshake towards the host-link TX
interface feature_map_streamer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  modport master(output tx_data, tx_valid, input tx_ready);
  modport slave(input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/feature_map_streamer.sv
// feature_map_streamer: latches pooled channel images and streams them as bytes; FEATURE_STREAM_HEADER_EN adds a per-channel header byte
module feature_map_streamer #(
  parameter int IMG_SIZE = 14,
  parameter int IC = 10,
  localparam int NBITS = IMG_SIZE * IMG_SIZE,
  localparam int NBYTES = (NBITS + 7) / 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 data_in_ready,
  input  logic [NBITS-1:0]     img_in [0:IC-1],
  feature_map_streamer_if.master tx,
  output logic                 busy,
  output logic                 done
);
  localparam int CW = IC > 1 ? $clog2(IC) : 1;
  localparam int BW = NBYTES > 1 ? $clog2(NBYTES) : 1;
`ifdef FEATURE_STREAM_HEADER_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, LOAD, HDR, SEND, DONE} state_t;
  state_t state;
  logic [NBITS-1:0] img_buf [0:IC-1];
  logic [CW-1:0] ch;
  logic [BW-1:0] bidx;
  logic acc, last_byte, last_ch;
  assign acc = tx.tx_valid && tx.tx_ready;
  assign last_byte = bidx == BW'(NBYTES - 1);
  assign last_ch = ch == CW'(IC - 1);
  function automatic logic [7:0] byte_at(input logic [CW-1:0] c, input logic [BW-1:0] b);
    logic [8*NBYTES-1:0] p;
    p = '0;
    p[NBITS-1:0] = img_buf[c];
    return p[8*b +: 8];
  endfunction
  // private copy of the frame, taken only at the IDLE sample so later img_in changes are ignored
  always_ff @(posedge clk)
    if (state == IDLE && data_in_ready) img_buf <= img_in;
  // frame sequencer; tx_data is preloaded with the next byte so every output stays registered
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      tx.tx_data <= '0;
      tx.tx_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      ch <= '0;
      bidx <= '0;
    end else if (state inside {LOAD, HDR, SEND} && !data_in_ready) begin
      state <= IDLE;
      tx.tx_valid <= 1'b0;
      busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (data_in_ready) begin
          state <= LOAD;
          busy <= 1'b1;
          ch <= '0;
          bidx <= '0;
        end
        LOAD: begin
          state <= HDR_EN ? HDR : SEND;
          tx.tx_valid <= 1'b1;
          tx.tx_data <= HDR_EN ? 8'hC0 : byte_at('0, '0);
        end
        HDR: if (acc) begin
          state <= SEND;
          tx.tx_data <= byte_at(ch, '0);
        end
        SEND: if (acc) begin
          if (!last_byte) begin
            bidx <= bidx + 1'b1;
            tx.tx_data <= byte_at(ch, bidx + 1'b1);
          end else if (last_ch) begin
            state <= DONE;
            tx.tx_valid <= 1'b0;
            busy <= 1'b0;
            done <= 1'b1;
            bidx <= '0;
          end else begin
            state <= HDR_EN ? HDR : SEND;
            bidx <= '0;
            ch <= ch + 1'b1;
            tx.tx_data <= HDR_EN ? {2'b11, 6'(ch + 1'b1)} : byte_at(ch + 1'b1, '0);
          end
        end
        DONE: if (!data_in_ready) begin
          state <= IDLE;
          done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_feature_map_streamer.sv
// tb_feature_map_streamer: directed frames checked byte-by-byte against a bit-level reference
module tb_feature_map_streamer;
  localparam int IMG_SIZE = 14;
  localparam int IC = 10;
  localparam int NBITS = IMG_SIZE * IMG_SIZE;
  localparam int NBYTES = (NBITS + 7) / 8;
`ifdef FEATURE_STREAM_HEADER_EN
  localparam int HDRB = 1;
`else
  localparam int HDRB = 0;
`endif
  localparam int BPC = NBYTES + HDRB;
  localparam int TOTAL = IC * BPC;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic data_in_ready = 1'b0;
  logic busy, done;
  logic [NBITS-1:0] img_in [0:IC-1];
  logic [NBITS-1:0] ref_img [0:IC-1];
  int n_chk = 0;
  int n_err = 0;
  int acc;
  feature_map_streamer_if tx();
  feature_map_streamer #(.IMG_SIZE(IMG_SIZE), .IC(IC)) dut (
    .clk(clk), .rst(rst), .data_in_ready(data_in_ready), .img_in(img_in),
    .tx(tx.master), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] exp_byte(input int k);
    int c = k / BPC;
    int o = k % BPC;
    int b = o - HDRB;
    logic [7:0] r = '0;
    if (HDRB == 1 && o == 0) return 8'hC0 | 8'(c);
    for (int j = 0; j < 8; j++) if (8 * b + j < NBITS) r[j] = ref_img[c][8*b+j];
    return r;
  endfunction
  task automatic set_pattern(input int pat);
    logic v;
    for (int c = 0; c < IC; c++)
      for (int i = 0; i < NBITS; i++) begin
        v = pat == 0 ? 1'b1 : pat == 1 ? (i == c) : (((i * 5 + c * 3) % 7) < 3);
        img_in[c][i] = v;
        ref_img[c][i] = v;
      end
  endtask
  task automatic start(input int pat);
    set_pattern(pat);
    @(negedge clk);
    data_in_ready = 1'b1;
    tx.tx_ready = 1'b1;
    @(negedge clk);
    for (int c = 0; c < IC; c++) img_in[c] = ~img_in[c];
    check("load_busy", busy, 1);
    check("load_valid", tx.tx_valid, 0);
  endtask
  task automatic stream(input int ready_pct, input int stop_at, output int n);
    int idx = 0;
    int cyc = 0;
    logic stalled = 1'b0;
    logic [7:0] held = '0;
    while (!tx.tx_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("first_valid", tx.tx_valid, 1);
    while (idx < TOTAL && idx < stop_at && cyc < 5000) begin
      if (ready_pct == 100) check("no_gap", tx.tx_valid, 1);
      if (stalled) begin
        check("stall_valid", tx.tx_valid, 1);
        check("stall_data", tx.tx_data, held);
      end
      if (tx.tx_valid) check($sformatf("byte%0d", idx), tx.tx_data, exp_byte(idx));
      tx.tx_ready = $urandom_range(99) < ready_pct;
      stalled = tx.tx_valid && !tx.tx_ready;
      held = tx.tx_data;
      if (tx.tx_valid && tx.tx_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    n = idx;
    tx.tx_ready = 1'b1;
  endtask
  task automatic finish_frame;
    check("done", done, 1);
    check("done_valid", tx.tx_valid, 0);
    check("done_busy", busy, 0);
    @(negedge clk);
    check("done_hold", done, 1);
    data_in_ready = 1'b0;
    @(negedge clk);
    check("done_clear", done, 0);
  endtask
  initial begin
    tx.tx_ready = 1'b0;
    for (int c = 0; c < IC; c++) img_in[c] = '0;
    repeat (2) @(negedge clk);
    check("rst_valid", tx.tx_valid, 0);
    check("rst_data", tx.tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    start(0);
    stream(100, 10, acc);
    #1 rst = 1'b1;
    data_in_ready = 1'b0;
    #1;
    check("arst_valid", tx.tx_valid, 0);
    check("arst_data", tx.tx_data, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    #1 rst = 1'b0;
    @(negedge clk);
    check("arst_idle_valid", tx.tx_valid, 0);
    check("arst_idle_busy", busy, 0);
    start(0);
    stream(100, TOTAL, acc);
    check("ones_count", acc, TOTAL);
    finish_frame();
    start(1);
    stream(100, TOTAL, acc);
    check("onehot_count", acc, TOTAL);
    finish_frame();
    start(0);
    stream(70, TOTAL, acc);
    check("stall_count", acc, TOTAL);
    finish_frame();
    start(2);
    stream(100, 37, acc);
    check("abort_count", acc, 37);
    data_in_ready = 1'b0;
    @(negedge clk);
    check("abort_valid", tx.tx_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    @(negedge clk);
    check("abort_idle", tx.tx_valid, 0);
    start(2);
    stream(100, TOTAL, acc);
    check("restart_count", acc, TOTAL);
    finish_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
